// File: rtl/set_sched.sv
// Job scheduler: two round-robin requesters feed a job FIFO; a dispatcher
// launches one job at a time on the set engine and returns its response.
module set_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 127
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][23:0]        req_central,
    input  logic [1:0][11:0]        req_radius,
    input  logic [1:0][1:0]         req_mode,
    output logic                    set_en,
    output logic [23:0]             set_central,
    output logic [11:0]             set_radius,
    output logic [1:0]              set_mode,
    input  logic                    set_busy,
    input  logic                    set_valid,
    input  logic [7:0]              set_candidate,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [7:0]              rsp_candidate,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef struct packed {
        logic        id;
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } job_t;

    job_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          prio;
    logic          grant;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    job_t          push_job;
    job_t          head;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    job_t          job_q;
    job_t          job_nxt;
    logic          set_en_nxt;
    logic          rsp_valid_nxt;
    logic          rsp_id_nxt;
    logic [7:0]    rsp_candidate_nxt;
    logic          rsp_err_nxt;

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    assign fifo_level = level;
    assign head       = mem[rd_ptr];

    // Round-robin winner: the priority holder if it asks, otherwise the other one.
    always_comb begin
        grant = prio;
        if (!req_valid[prio]) begin
            grant = ~prio;
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && !full && (|req_valid)) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign push             = |(req_valid & req_ready);
    assign push_job.id      = grant;
    assign push_job.central = req_central[grant];
    assign push_job.radius  = req_radius[grant];
    assign push_job.mode    = req_mode[grant];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_job;
        end
    end

    // FIFO pointers, occupancy and arbitration priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            prio   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                prio   <= ~grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Dispatcher next-state and registered-output logic.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        job_nxt           = job_q;
        set_en_nxt        = 1'b0;
        rsp_valid_nxt     = rsp_valid;
        rsp_id_nxt        = rsp_id;
        rsp_candidate_nxt = rsp_candidate;
        rsp_err_nxt       = rsp_err;
        pop               = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !set_busy) begin
                    pop        = 1'b1;
                    job_nxt    = head;
                    set_en_nxt = 1'b1;
                    state_nxt  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A valid arriving on the last allowed cycle wins over the timeout.
                if (set_valid) begin
                    rsp_valid_nxt     = 1'b1;
                    rsp_id_nxt        = job_q.id;
                    rsp_candidate_nxt = set_candidate;
                    rsp_err_nxt       = 1'b0;
                    cnt_nxt           = '0;
                    state_nxt         = S_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rsp_valid_nxt     = 1'b1;
                    rsp_id_nxt        = job_q.id;
                    rsp_candidate_nxt = 8'h00;
                    rsp_err_nxt       = 1'b1;
                    cnt_nxt           = '0;
                    state_nxt         = S_RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            job_q         <= '0;
            set_en        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_candidate <= 8'h00;
            rsp_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            job_q         <= job_nxt;
            set_en        <= set_en_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_id        <= rsp_id_nxt;
            rsp_candidate <= rsp_candidate_nxt;
            rsp_err       <= rsp_err_nxt;
        end
    end

    assign set_central = job_q.central;
    assign set_radius  = job_q.radius;
    assign set_mode    = job_q.mode;

endmodule

// File: tb/tb_set_sched.sv
// Directed bench for set_sched with a simple delayed-response engine model.
module tb_set_sched;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 127;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][23:0] req_central;
    logic [1:0][11:0] req_radius;
    logic [1:0][1:0]  req_mode;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [7:0]       rsp_candidate;
    logic             rsp_err;
    logic [2:0]       fifo_level;

    int   checks   = 0;
    int   failures = 0;
    logic eng_on;
    int   eng_delay;
    logic use_fixed;
    logic [7:0] fixed_cand;

    set_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_candidate(rsp_candidate), .rsp_err(rsp_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Engine: answers eng_delay edges after seeing set_en (candidate = central low byte).
    always begin
        @(posedge clk);
        #1;
        if (set_en && eng_on) begin
            set_candidate = use_fixed ? fixed_cand : set_central[7:0];
            repeat (eng_delay) @(posedge clk);
            #1 set_valid = 1'b1;
            @(posedge clk);
            #1 set_valid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        set_busy  = 1'b0;
        eng_on    = 1'b0;
        use_fixed = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        req_valid   = 2'b11;
        req_central = '0;
        req_radius  = '0;
        req_mode    = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++;
        if ({set_en, rsp_valid, rsp_err, rsp_id} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {set_en, rsp_valid, rsp_err, rsp_id});
        end
        checks++;
        if (rsp_candidate !== 8'h00) begin failures++; $display("FAIL reset_cand got=%h exp=00", rsp_candidate); end
        checks++;
        if ({set_central, set_radius, set_mode} !== 38'h0) begin
            failures++; $display("FAIL reset_set got=%h exp=0", {set_central, set_radius, set_mode});
        end
        checks++;
        if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_job;
        int cyc;
        int pulses;
        do_reset;
        eng_on = 1'b1; eng_delay = 66; use_fixed = 1'b1; fixed_cand = 8'h12;
        @(negedge clk);
        req_central[0] = 24'h334455; req_radius[0] = 12'h345; req_mode[0] = 2'd1;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if ({fifo_level, set_en} !== {3'd1, 1'b0}) begin
            failures++; $display("FAIL single_queued got=%0d/%b exp=1/0", fifo_level, set_en);
        end
        @(negedge clk);
        checks++;
        if ({set_en, fifo_level} !== {1'b1, 3'd0}) begin
            failures++; $display("FAIL single_launch got=%b/%0d exp=1/0", set_en, fifo_level);
        end
        checks++;
        if ({set_central, set_radius, set_mode} !== {24'h334455, 12'h345, 2'd1}) begin
            failures++; $display("FAIL single_payload got=%h/%h/%0d exp=334455/345/1", set_central, set_radius, set_mode);
        end
        cyc = 0; pulses = 0;
        while (!rsp_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (set_en) pulses++;
        end
        checks++;
        if (cyc !== 67) begin failures++; $display("FAIL single_rsp_time got=%0d exp=67", cyc); end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL single_extra_set_en got=%0d exp=0", pulses); end
        checks++;
        if ({rsp_id, rsp_candidate, rsp_err} !== {1'b0, 8'h12, 1'b0}) begin
            failures++; $display("FAIL single_rsp got=%b/%h/%b exp=0/12/0", rsp_id, rsp_candidate, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
        use_fixed = 1'b0;
    endtask

    task automatic test_contention;
        int sent0, sent1, gcnt, rcnt;
        int r;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        do_reset;
        eng_on = 1'b1; eng_delay = 3; rsp_ready = 1'b1;
        sent0 = 0; sent1 = 0; gcnt = 0; rcnt = 0;
        for (int cyc = 0; cyc < 2000 && rcnt < 12; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                if ({rsp_id, rsp_candidate} !== e) begin
                    failures++; $display("FAIL cont_rsp%0d got=%h exp=%h", rcnt, {rsp_id, rsp_candidate}, e);
                end
                rcnt++;
            end
            req_valid[0]   = (sent0 < 6);
            req_valid[1]   = (sent1 < 6);
            req_central[0] = 24'(8'h00 + sent0);
            req_central[1] = 24'(8'h10 + sent1);
            req_radius[0]  = 12'h00A; req_radius[1] = 12'h00B;
            req_mode[0]    = 2'd2;    req_mode[1]   = 2'd3;
            #1;
            if (|(req_valid & req_ready)) begin
                r = req_ready[1] ? 1 : 0;
                checks++;
                if (req_ready !== ((gcnt % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL cont_grant%0d got=%b exp=%0d", gcnt, req_ready, gcnt % 2);
                end
                if (r == 0) begin exp_q.push_back({1'b0, 8'(8'h00 + sent0)}); sent0++; end
                else        begin exp_q.push_back({1'b1, 8'(8'h10 + sent1)}); sent1++; end
                gcnt++;
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        checks++;
        if ({gcnt, rcnt} !== {32'd12, 32'd12}) begin
            failures++; $display("FAIL cont_count got=%0d/%0d exp=12/12", gcnt, rcnt);
        end
    endtask

    task automatic test_full_fifo;
        logic [1:0] exp_rdy;
        do_reset;
        set_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_central[0] = 24'(24'h100 + k); req_radius[0] = 12'h001; req_mode[0] = 2'd0;
            req_valid = 2'b01;
            #1;
            exp_rdy = (k < 4) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== exp_rdy) begin failures++; $display("FAIL full_ready%0d got=%b exp=%b", k, req_ready, exp_rdy); end
        end
        checks++;
        if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, set_en, fifo_level} !== {2'b00, 1'b0, 3'd4}) begin
            failures++; $display("FAIL full_hold got=%b/%b/%0d exp=00/0/4", req_ready, set_en, fifo_level);
        end
        set_busy = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({fifo_level, req_ready, set_en} !== {3'd3, 2'b01, 1'b1}) begin
            failures++; $display("FAIL full_pop got=%0d/%b/%b exp=3/01/1", fifo_level, req_ready, set_en);
        end
        checks++;
        if (set_central !== 24'h100) begin failures++; $display("FAIL full_head got=%h exp=100", set_central); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (fifo_level !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", fifo_level); end
    endtask

    task automatic test_timeout;
        int cyc;
        do_reset;
        @(negedge clk);
        req_central[0] = 24'h0000A1; req_radius[0] = 12'h001; req_mode[0] = 2'd1;
        req_valid = 2'b01;
        @(negedge clk);
        req_central[1] = 24'h0000B2; req_radius[1] = 12'h002; req_mode[1] = 2'd2;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL to_rr_ready got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (set_en !== 1'b1) begin failures++; $display("FAIL to_launch got=%b exp=1", set_en); end
        eng_on = 1'b1; eng_delay = 127;
        wait_rsp(cyc);
        checks++;
        if (cyc !== 128) begin failures++; $display("FAIL to_time got=%0d exp=128", cyc); end
        checks++;
        if ({rsp_id, rsp_candidate, rsp_err, fifo_level} !== {1'b0, 8'h00, 1'b1, 3'd1}) begin
            failures++; $display("FAIL to_rsp got=%b/%h/%b/%0d exp=0/00/1/1", rsp_id, rsp_candidate, rsp_err, fifo_level);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({set_en, set_central} !== {1'b1, 24'h0000B2}) begin
            failures++; $display("FAIL to_next_launch got=%b/%h exp=1/0000b2", set_en, set_central);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc !== 128) begin failures++; $display("FAIL to_edge_time got=%0d exp=128", cyc); end
        checks++;
        if ({rsp_id, rsp_candidate, rsp_err} !== {1'b1, 8'hB2, 1'b0}) begin
            failures++; $display("FAIL to_edge_rsp got=%b/%h/%b exp=1/b2/0", rsp_id, rsp_candidate, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int cyc;
        do_reset;
        eng_on = 1'b1; eng_delay = 2;
        @(negedge clk);
        req_central[0] = 24'h0000C3; req_valid = 2'b01;
        @(negedge clk);
        req_central[1] = 24'h0000D4; req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(cyc);
        checks++;
        if ({rsp_valid, rsp_id, rsp_candidate} !== {1'b1, 1'b0, 8'hC3}) begin
            failures++; $display("FAIL bp_first got=%b/%b/%h exp=1/0/c3", rsp_valid, rsp_id, rsp_candidate);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_candidate, rsp_err, set_en, fifo_level} !== {1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 3'd1}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%b/%h/%b/%b/%0d exp=1/0/c3/0/0/1", i, rsp_valid, rsp_id, rsp_candidate, rsp_err, set_en, fifo_level);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, set_en} !== 2'b00) begin failures++; $display("FAIL bp_accept got=%b exp=00", {rsp_valid, set_en}); end
        @(negedge clk);
        checks++;
        if ({set_en, set_central} !== {1'b1, 24'h0000D4}) begin
            failures++; $display("FAIL bp_relaunch got=%b/%h exp=1/0000d4", set_en, set_central);
        end
        wait_rsp(cyc);
        checks++;
        if ({rsp_id, rsp_candidate, rsp_err} !== {1'b1, 8'hD4, 1'b0}) begin
            failures++; $display("FAIL bp_second got=%b/%h/%b exp=1/d4/0", rsp_id, rsp_candidate, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_central[0] = 24'(24'h200 + k); req_valid = 2'b01;
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({fifo_level, rsp_valid} !== {3'd3, 1'b0}) begin
            failures++; $display("FAIL rmw_pre got=%0d/%b exp=3/0", fifo_level, rsp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_level, set_en, rsp_valid, set_central} !== {3'd0, 1'b0, 1'b0, 24'h0}) begin
            failures++; $display("FAIL rmw_clear got=%0d/%b/%b/%h exp=0/0/0/0", fifo_level, set_en, rsp_valid, set_central);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid || set_en || fifo_level != 3'd0) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rmw_quiet got=%0d exp=0", seen); end
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 2'b00;
        req_central   = '0;
        req_radius    = '0;
        req_mode      = '0;
        set_busy      = 1'b0;
        set_valid     = 1'b0;
        set_candidate = 8'h00;
        rsp_ready     = 1'b0;
        eng_on        = 1'b0;
        eng_delay     = 1;
        use_fixed     = 1'b0;
        fixed_cand    = 8'h00;
        #2;
        test_reset;
        test_single_job;
        test_contention;
        test_full_fifo;
        test_timeout;
        test_backpressure;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/set_sched.md
SET_SCHED -- requirements
Module: set_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, job FIFO depth (power of 2, min 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 127, max cycles in WAIT before abort.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports req_valid[r]/req_ready[r]  input/output  1 each, r=0,1  per-requester handshake.
REQ-006 The block SHALL have ports req_central[r]  input  24; req_radius[r]  input  12; req_mode[r]  input  2  (r=0,1), job payload.
REQ-007 The block SHALL have ports set_en  output  1; set_central  output  24; set_radius  output  12; set_mode  output  2  (to engine).
REQ-008 The block SHALL have ports set_busy  input  1; set_valid  input  1; set_candidate  input  8  (from engine).
REQ-009 The block SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1; rsp_candidate  output  8; rsp_err  output  1.
REQ-010 The block SHALL have ports fifo_level  output  log2(DEPTH)+1  occupancy.

Function
REQ-011 Admission: at most one job SHALL enter the FIFO per cycle; it enters when req_valid[r] & req_ready[r].
REQ-012 req_ready[r] SHALL be 1 only for the arbitration winner, and only when FIFO is not full (combinational on req_valid and pointer state).
REQ-013 Arbitration SHALL be round-robin: on both valid, grant the requester not granted last; priority pointer updates only on an accepted transfer; after reset requester 0 has priority.
REQ-014 Each FIFO entry SHALL store {id, central, radius, mode} (39 bits).
REQ-015 FIFO SHALL be full at DEPTH entries and empty at 0; pointers wrap modulo DEPTH; simultaneous push and pop on a full FIFO SHALL NOT be allowed (ready low when full), on a non-empty non-full FIFO both take effect and level is unchanged.
REQ-016 Dispatcher FSM states SHALL be IDLE, LAUNCH, WAIT, RESP.
REQ-017 IDLE->LAUNCH when FIFO non-empty and set_busy==0; the head entry is popped and latched into set_central/radius/mode and an internal id register in that transition.
REQ-018 In LAUNCH set_en SHALL be 1 for exactly one cycle, then -> WAIT; set_en SHALL be 0 in every other state.
REQ-019 set_central/set_radius/set_mode SHALL stay stable from LAUNCH until leaving WAIT.
REQ-020 In WAIT a cycle counter increments each cycle; on set_valid==1 candidate is captured, rsp_err=0, -> RESP.
REQ-021 If counter reaches TIMEOUT without set_valid, rsp_candidate=0, rsp_err=1, -> RESP; set_valid and timeout in the same cycle SHALL resolve as valid (no error).
REQ-022 set_valid outside WAIT SHALL be ignored.
REQ-023 In RESP rsp_valid=1 with rsp_id/rsp_candidate/rsp_err stable until rsp_ready==1; on that cycle -> IDLE.
REQ-024 The dispatcher SHALL NOT launch a new job until the current response is accepted (one job in flight).
REQ-025 Latency: an enqueued job reaching an empty FIFO with idle engine SHALL assert set_en 2 cycles after the accepting edge (IDLE pop edge, LAUNCH cycle).
REQ-026 fifo_level SHALL reflect occupancy after every edge, 0..DEPTH.

Reset
REQ-027 On rst low all state SHALL clear asynchronously: FSM=IDLE, FIFO empty, fifo_level=0, RR pointer=requester 0, counter=0.
REQ-028 During reset set_en=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_candidate=0, set_central/radius/mode=0, req_ready=0.
REQ-029 Reset asserted mid-job SHALL abandon the job and all queued jobs with no response emitted; release is synchronized to clk by the integrator.

Verification
REQ-030 Single job: req0 central=0x334455, radius=0x345, mode=1, engine model returns valid with candidate=0x12 after 66 cycles -> one set_en pulse, rsp_valid with id=0, candidate=0x12, err=0.
REQ-031 Contention: both requesters valid continuously, 6 jobs each, rsp_ready=1 -> grants alternate 0,1,0,1..., responses returned in grant order, no loss.
REQ-032 Full FIFO: engine stalled (set_busy=1), push 5 jobs with DEPTH=4 -> fifo_level=4, req_ready=0 on 5th until a pop occurs.
REQ-033 Timeout: engine never asserts valid -> rsp_valid exactly TIMEOUT cycles after WAIT entry with err=1, candidate=0; next job then launches normally.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles in RESP -> outputs stable, set_en stays 0, no new launch until acceptance.
REQ-035 Reset mid-WAIT with 3 queued jobs -> immediate IDLE, fifo_level=0, no rsp_valid after release.
